exe_muldiv_seq: RTL and testbench
=================================

// Module: exe_muldiv_seq
// PURPOSE
// - Multi-cycle multiply/divide sequencer beside the single-cycle EXE-stage ALU.
// - Accepts a MUL/DIV command from EXE, freezes the pipeline via stall, runs a radix-2 iterative datapath, returns HI/LO.
// - A flush from a taken branch cancels the operation.
// PARAMETERS
// - WIDTH  32  operand width; HI/LO are each WIDTH bits.
// - ITERS  32  iterations in RUN; must equal WIDTH.
// PORTS
// - clk         in   1      rising-edge clock.
// - rst_n       in   1      asynchronous, active-low reset.
// - start       in   1      EXE holds a valid mul/div op this cycle.
// - op          in   2      0 MULU, 1 MUL, 2 DIVU, 3 DIV.
// - dataa       in   WIDTH  multiplicand / dividend (forwarded readdata1).
// - datab       in   WIDTH  multiplier / divisor (forwarded data2).
// - flush       in   1      cancel in-flight op (branch_taken of older instr).
// - stall       out  1      freeze IF/ID/EXE registers.
// - busy        out  1      FSM not IDLE.
// - done        out  1      one-cycle pulse; hi/lo valid.
// - div_zero    out  1      with done: divide had datab==0.
// - hi, lo      out  WIDTH  product hi/lo, or remainder/quotient.
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; stall, busy, done, div_zero = 0; hi, lo = 0; internal regs cleared.
// - States: IDLE, PREP, RUN, FIX, DONE.
// - IDLE: start && !flush -> PREP; latch op and operands.
// - IDLE: stall = start && !flush (combinational), so the issuing instruction holds in EXE.
// - PREP: signed ops take magnitudes; record result sign (MUL: sa^sb; DIV: quotient sa^sb, remainder sa).
// - PREP, divide with datab==0 -> DONE: lo=all-ones, hi=dataa, div_zero=1.
// - PREP, all other cases -> RUN; iteration counter = ITERS-1.
// - RUN, multiply: shift-add on {acc,mplier} each cycle.
// - RUN, divide: restoring shift-subtract on {rem,quot} each cycle.
// - RUN: counter decrements; at 0 -> FIX.
// - FIX: apply 2's-complement negation per recorded signs -> DONE.
// - DONE: hi/lo registered; done=1 for exactly this cycle; stall=0 -> IDLE next cycle.
// - Latency: start cycle T, done at T+ITERS+3 (T+35 for WIDTH=32); stall high T..T+ITERS+2.
// - Divide-by-zero latency: done at T+2.
// - hi/lo hold their last value until the next DONE; they never change mid-operation.
// - start while busy: ignored (pipeline is stalled; EXE presents the same instruction).
// - Back-to-back: start in the cycle after DONE accepted normally (IDLE).
// - flush in any state but DONE: next state IDLE; stall/busy drop next cycle; no done; hi/lo unchanged.
// - flush in DONE: done still pulses (op completed); FSM -> IDLE.
// - flush && start in IDLE: start ignored.
// - Signed DIV overflow (-2^(W-1) / -1): lo = 0x8000_0000, hi = 0 (wrap), div_zero=0.
// - Width rules: multiply is exact 2W-bit product {hi,lo}.
// - Width rules: divide truncates toward zero; remainder sign = dividend sign; |rem| < |divisor|.
// - Unused op codes: none (2-bit op fully decoded).
// STRUCTURE
// - Shared package exe_pkg: op encodings (OP_MULU..OP_DIV), FSM state localparams, WIDTH default.
// - Sub-module muldiv_step (combinational): one shift-add or shift-subtract iteration, selected by a mul/div bit.
// - Top holds FSM, counter, sign flags, HI/LO regs; no other hierarchy.
// TESTING
// - MULU 0xFFFF_FFFF*0xFFFF_FFFF -> done at T+35, hi=0xFFFF_FFFE, lo=0x0000_0001, stall high 35 cycles.
// - MUL -7*3 -> {hi,lo}=0xFFFF_FFFF_FFFF_FFEB; DIV -7/2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1).
// - DIVU 100/0 -> done at T+2, div_zero=1, lo=0xFFFF_FFFF, hi=100.
// - DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0, div_zero=0.
// - flush at T+10 of DIVU 9/2 -> IDLE at T+11, no done, hi/lo keep previous result.
// - rst_n low at T+5 (async) -> outputs 0 immediately; then two back-to-back MULU 3*4, 5*6 -> lo=12 then lo=30, done pulses 36 cycles apart.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the EXE-stage multiply/divide sequencer.
package exe_pkg;
  localparam int EXE_WIDTH = 32;

  localparam logic [1:0] OP_MULU = 2'd0;
  localparam logic [1:0] OP_MUL  = 2'd1;
  localparam logic [1:0] OP_DIVU = 2'd2;
  localparam logic [1:0] OP_DIV  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply on {acc,q} or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH:0] w_sum, w_sh, w_diff;

  always_comb begin
    w_sum  = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
    w_sh   = {i_acc, i_q[WIDTH-1]};
    // rem < divisor holds every step, so the MSB of the difference is a clean borrow flag
    w_diff = w_sh - {1'b0, i_b};
    if (i_div) begin
      o_acc = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
      o_q   = {i_q[WIDTH-2:0], ~w_diff[WIDTH]};
    end else begin
      o_acc = w_sum[WIDTH:1];
      o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/exe_muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer: stalls EXE, iterates a radix-2 datapath, returns HI/LO.
module exe_muldiv_seq
  import exe_pkg::*;
#(
  parameter int WIDTH = EXE_WIDTH,
  parameter int ITERS = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(ITERS);

  state_e             r_state, w_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_acc, r_q, r_hi, r_lo;
  logic [CW-1:0]      r_cnt;
  logic               r_sq, r_sr, r_dz;

  logic               w_div, w_sa, w_sb, w_bz, w_accept;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_acc_n, w_q_n, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;

  assign w_div    = r_op[1];
  assign w_sa     = r_op[0] & r_a[WIDTH-1];
  assign w_sb     = r_op[0] & r_b[WIDTH-1];
  assign w_bz     = (r_b == '0);
  assign w_mag_a  = w_sa ? -r_a : r_a;
  assign w_mag_b  = w_sb ? -r_b : r_b;
  assign w_accept = start && !flush;

  // Sign fix-up: a product is negated as a whole, quotient and remainder separately
  assign w_prod = r_sq ? -{r_acc, r_q} : {r_acc, r_q};
  assign w_quo  = r_sq ? -r_q : r_q;
  assign w_rem  = r_sr ? -r_acc : r_acc;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (w_div),
    .i_acc (r_acc),
    .i_q   (r_q),
    .i_b   (r_b),
    .o_acc (w_acc_n),
    .o_q   (w_q_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_accept;
        if (w_accept) w_nxt = S_PREP;
      end
      S_PREP: begin
        stall = 1'b1;
        w_nxt = (w_div && w_bz) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        stall = 1'b1;
        if (r_cnt == '0) w_nxt = S_FIX;
      end
      S_FIX: begin
        stall = 1'b1;
        w_nxt = S_DONE;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
    if (flush && r_state != S_DONE) w_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_sq  <= 1'b0;
      r_sr  <= 1'b0;
      r_dz  <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= op;
          r_a  <= dataa;
          r_b  <= datab;
        end
        S_PREP: begin
          r_acc <= '0;
          r_q   <= w_mag_a;
          r_b   <= w_mag_b;
          r_sq  <= w_sa ^ w_sb;
          r_sr  <= w_sa;
          r_cnt <= CW'(ITERS - 1);
          if (!flush && w_div && w_bz) begin
            r_hi <= r_a;
            r_lo <= '1;
            r_dz <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: if (!flush) begin
          r_hi <= w_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_div ? w_quo : w_prod[WIDTH-1:0];
          r_dz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign div_zero = done & r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;
endmodule

// File: tb/tb_exe_muldiv_seq.sv
// Scoreboard bench for exe_muldiv_seq: expected results queued at issue, checked on done.
module tb_exe_muldiv_seq;
  logic        clk, rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] dataa, datab;
  logic        stall, busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          t0;
    int          lat;
    int          stl;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, stall_cnt = 0, prev_done = 0, last_done = 0;

  exe_muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dataa(dataa), .datab(datab),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // {div_zero, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = sa * sb;
      2'd2: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        p = {a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        p = {r[31:0], q[31:0]};
      end
    endcase
    return {1'b0, p};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && stall) stall_cnt++;
    if (done) begin
      if (sb.size() == 0) chk("spurious_done", {63'd0, done}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
        chk("latency", 64'(cyc - e.t0), 64'(e.lat));
        chk("stall_cycles", 64'(stall_cnt), 64'(e.stl));
        prev_done = last_done;
        last_done = cyc;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the start window
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input int hold);
    exp_t e;
    logic [64:0] m;
    start = 1'b1; op = o; dataa = a; datab = b; stall_cnt = 0;
    if (push) begin
      m = model(o, a, b);
      e.dz = m[64]; e.hi = m[63:32]; e.lo = m[31:0];
      e.t0 = cyc; e.lat = m[64] ? 2 : 35; e.stl = m[64] ? 2 : 35;
      sb.push_back(e);
    end
    repeat (hold) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; dataa = '0; datab = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", {busy, stall, done, div_zero, hi, lo}, 68'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1); wait_idle();
    issue(2'd1, -32'sd7, 32'd3, 1, 1);               wait_idle();
    issue(2'd3, -32'sd7, 32'd2, 1, 1);               wait_idle();
    issue(2'd2, 32'd100, 32'd0, 1, 1);               wait_idle();
    issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1); wait_idle();
    issue(2'd3, 32'd5, 32'd0, 1, 1);                 wait_idle();
    // start held while busy must not re-issue
    issue(2'd2, 32'd100, 32'd7, 1, 3);               wait_idle();
    for (int i = 0; i < 6; i++) begin
      issue(2'($urandom_range(0, 3)), $urandom, (i % 2) ? $urandom_range(1, 50) : $urandom, 1, 1);
      wait_idle();
    end

    // flush during DONE: result still delivered
    issue(2'd0, 32'h1234_5678, 32'h10, 1, 1);
    repeat (34) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("busy_after_done_flush", {63'd0, busy}, 64'd0);
    wait_idle();

    // flush mid-divide: op cancelled, results retained
    issue(2'd2, 32'd9, 32'd2, 0, 1);
    repeat (9) begin @(posedge clk); #1; end
    chk("busy_before_flush", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("busy_after_flush", {63'd0, busy}, 64'd0);
    chk("stall_after_flush", {63'd0, stall}, 64'd0);
    repeat (40) begin @(posedge clk); #1; end
    chk("hi_kept", {32'd0, hi}, 64'h1);
    chk("lo_kept", {32'd0, lo}, 64'h2345_6780);

    // flush together with start in IDLE: start ignored
    start = 1'b1; flush = 1'b1; op = 2'd0; dataa = 32'd2; datab = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ignored", {63'd0, busy}, 64'd0);

    // asynchronous reset in the middle of an op
    issue(2'd0, 32'd3, 32'd4, 0, 1);
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {busy, stall, done, div_zero, hi, lo}, 68'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'd0, 32'd3, 32'd4, 1, 1); wait_idle();
    issue(2'd0, 32'd5, 32'd6, 1, 1); wait_idle();
    chk("b2b_spacing", 64'(last_done - prev_done), 64'd36);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
